// File: rtl/core_pkg.sv
// Shared core definitions: datapath width, register-file geometry, RV load
// funct3 encodings and the writeback unit's buffer state type.
package core_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned NREG = 32;

  // RV64 load funct3 encodings.
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  localparam logic [4:0] REG_X0 = 5'd0;

  // One-entry load buffer occupancy.
  typedef enum logic [0:0] {
    StEmpty = 1'b0,
    StHeld  = 1'b1
  } buf_state_e;

endpackage

// File: rtl/load_ext.sv
// Load data extension.
// Takes right-aligned raw load data and sign- or zero-extends it to XLEN
// according to the RV load funct3. Purely combinational; reusable by the LSU.
// Ports:
//   funct3 - RV load funct3 (LB/LH/LW/LD/LBU/LHU/LWU, 111 reserved)
//   raw    - raw load data, right-aligned
//   ext    - extended result
module load_ext #(
  parameter int unsigned XLEN = core_pkg::XLEN
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] raw,
  output logic [XLEN-1:0] ext
);
  import core_pkg::*;

  always_comb begin
    ext = raw;
    case (funct3)
      F3_LB:   ext = {{(XLEN - 8){raw[7]}}, raw[7:0]};
      F3_LH:   ext = {{(XLEN - 16){raw[15]}}, raw[15:0]};
      F3_LW:   ext = {{(XLEN - 32){raw[31]}}, raw[31:0]};
      F3_LD:   ext = raw;
      F3_LBU:  ext = {{(XLEN - 8){1'b0}}, raw[7:0]};
      F3_LHU:  ext = {{(XLEN - 16){1'b0}}, raw[15:0]};
      F3_LWU:  ext = {{(XLEN - 32){1'b0}}, raw[31:0]};
      // Reserved encoding passes the data through untouched.
      default: ext = raw;
    endcase
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter for the RV64 core.
// Merges the single-cycle ALU result path and the multi-cycle load-response
// path onto the register-file write port. A one-entry buffer absorbs a load
// that collides with an ALU result; a starvation counter stalls the ALU when a
// buffered load has waited too long. A load scoreboard tracks destinations of
// in-flight loads so issue logic can stall on them.
// Ports:
//   clk, nrst                       - clock, asynchronous active-low reset
//   alu_valid/alu_rd/alu_data       - ALU result (no backpressure)
//   alu_stall                       - upstream must hold off alu_valid
//   ld_valid/ld_ready/ld_rd/
//   ld_funct3/ld_data               - load response handshake
//   iss_valid/iss_rd                - load issue, marks iss_rd pending
//   chk_addr1/2, chk_busy1/2        - scoreboard queries (combinational)
//   wr_addr/wrdata/wr_en            - registered register-file write port
module wb_arbiter #(
  parameter int unsigned XLEN       = core_pkg::XLEN,
  parameter int unsigned NREG       = core_pkg::NREG,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_stall,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [4:0]      ld_rd,
  input  logic [2:0]      ld_funct3,
  input  logic [XLEN-1:0] ld_data,
  input  logic            iss_valid,
  input  logic [4:0]      iss_rd,
  input  logic [4:0]      chk_addr1,
  input  logic [4:0]      chk_addr2,
  output logic            chk_busy1,
  output logic            chk_busy2,
  output logic [4:0]      wr_addr,
  output logic [XLEN-1:0] wrdata,
  output logic            wr_en
);
  import core_pkg::*;

  localparam int unsigned CntW = $clog2(STARVE_MAX + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STARVE_MAX);

  buf_state_e state_q, state_d;

  // Low during reset and for the first edge after release, so ld_ready only
  // rises once the unit is actually clocking.
  logic rst_done_q;

  logic [4:0]      buf_rd_q, buf_rd_d;
  logic [XLEN-1:0] buf_data_q, buf_data_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            stall_q, stall_d;
  logic            wr_en_q, wr_en_d;
  logic [4:0]      wr_addr_q, wr_addr_d;
  logic [XLEN-1:0] wrdata_q, wrdata_d;
  // Marks the write currently on the port as load-sourced (scoreboard clear).
  logic            wr_load_q, wr_load_d;
  logic [NREG-1:0] pending_q, pending_d;

  logic            ld_acc;
  logic [XLEN-1:0] ld_ext_data;
  logic            win_valid;
  logic            win_load;
  logic [4:0]      win_rd;
  logic [XLEN-1:0] win_data;

  load_ext #(
    .XLEN (XLEN)
  ) u_load_ext (
    .funct3 (ld_funct3),
    .raw    (ld_data),
    .ext    (ld_ext_data)
  );

  assign ld_acc = ld_valid & ld_ready;

  // ---------------------------------------------------------------------------
  // Buffer FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty: if (alu_valid && ld_acc) state_d = StHeld;
      StHeld:  if (!alu_valid) state_d = StEmpty;
      default: state_d = StEmpty;
    endcase
  end

  always_comb begin
    ld_ready = rst_done_q && (state_q == StEmpty);
  end

  // ---------------------------------------------------------------------------
  // Winner selection: ALU, then buffered load, then direct load
  // ---------------------------------------------------------------------------
  always_comb begin
    buf_rd_d   = buf_rd_q;
    buf_data_d = buf_data_q;
    win_valid  = 1'b0;
    win_load   = 1'b0;
    win_rd     = REG_X0;
    win_data   = '0;

    if (alu_valid) begin
      win_valid = 1'b1;
      win_rd    = alu_rd;
      win_data  = alu_data;
      if (ld_acc) begin
        buf_rd_d   = ld_rd;
        buf_data_d = ld_ext_data;
      end
    end else if (state_q == StHeld) begin
      win_valid = 1'b1;
      win_load  = 1'b1;
      win_rd    = buf_rd_q;
      win_data  = buf_data_q;
    end else if (ld_acc) begin
      win_valid = 1'b1;
      win_load  = 1'b1;
      win_rd    = ld_rd;
      win_data  = ld_ext_data;
    end

    // An x0 winner still consumes its slot but produces no write.
    wr_en_d   = win_valid && (win_rd != REG_X0);
    wr_addr_d = win_rd;
    wrdata_d  = win_data;
    wr_load_d = win_load && wr_en_d;
  end

  // ---------------------------------------------------------------------------
  // Starvation tracking
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_d = cnt_q;
    if (state_d == StEmpty) begin
      cnt_d = '0;
    end else if ((state_q == StHeld) && alu_valid && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + 1'b1;
    end
    stall_d = (state_d == StHeld) && (cnt_d == CntMax);
  end

  // ---------------------------------------------------------------------------
  // Load scoreboard
  // ---------------------------------------------------------------------------
  always_comb begin
    pending_d = pending_q;
    // Clear on the edge the register file captures the load write.
    if (wr_en_q && wr_load_q) begin
      pending_d[wr_addr_q] = 1'b0;
    end
    // Applied after the clear so a same-edge set wins.
    if (iss_valid && (iss_rd != REG_X0)) begin
      pending_d[iss_rd] = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rst_done_q <= 1'b0;
      buf_rd_q   <= REG_X0;
      buf_data_q <= '0;
      cnt_q      <= '0;
      stall_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= REG_X0;
      wrdata_q   <= '0;
      wr_load_q  <= 1'b0;
      pending_q  <= '0;
    end else begin
      rst_done_q <= 1'b1;
      buf_rd_q   <= buf_rd_d;
      buf_data_q <= buf_data_d;
      cnt_q      <= cnt_d;
      stall_q    <= stall_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wrdata_q   <= wrdata_d;
      wr_load_q  <= wr_load_d;
      pending_q  <= pending_d;
    end
  end

  assign alu_stall = stall_q;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wrdata    = wrdata_q;
  assign chk_busy1 = pending_q[chk_addr1];
  assign chk_busy2 = pending_q[chk_addr2];

`ifndef SYNTHESIS
  // Upstream must honour alu_stall; the datapath still favours the ALU if not.
  a_no_alu_while_stalled: assert property (
    @(posedge clk) disable iff (!nrst) alu_stall |-> !alu_valid
  );
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus randomized
// traffic against a behavioural reference model; register-file writes are
// checked by a scoreboard queue drained by an independent monitor.
module tb_wb_arbiter;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned STARVE = 4;

  logic            clk;
  logic            nrst;
  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            alu_stall;
  logic            ld_valid;
  logic            ld_ready;
  logic [4:0]      ld_rd;
  logic [2:0]      ld_funct3;
  logic [XLEN-1:0] ld_data;
  logic            iss_valid;
  logic [4:0]      iss_rd;
  logic [4:0]      chk_addr1;
  logic [4:0]      chk_addr2;
  logic            chk_busy1;
  logic            chk_busy2;
  logic [4:0]      wr_addr;
  logic [XLEN-1:0] wrdata;
  logic            wr_en;

  wb_arbiter #(
    .XLEN       (XLEN),
    .NREG       (32),
    .STARVE_MAX (STARVE)
  ) dut (
    .clk       (clk),
    .nrst      (nrst),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .alu_stall (alu_stall),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_rd     (ld_rd),
    .ld_funct3 (ld_funct3),
    .ld_data   (ld_data),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .chk_addr1 (chk_addr1),
    .chk_addr2 (chk_addr2),
    .chk_busy1 (chk_busy1),
    .chk_busy2 (chk_busy2),
    .wr_addr   (wr_addr),
    .wrdata    (wrdata),
    .wr_en     (wr_en)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct {
    int          cyc;
    logic [4:0]  rd;
    logic [63:0] data;
  } exp_t;

  exp_t        sb_q[$];
  bit          m_held;
  logic [4:0]  m_hrd;
  logic [63:0] m_hdata;
  int          m_cnt;
  bit          m_stall;
  logic [31:0] m_pend;
  bit          m_clr_v;
  logic [4:0]  m_clr_rd;

  // Extension expressed as shift arithmetic on the bottom n bits.
  function automatic logic [63:0] m_ext(input logic [2:0] f3, input logic [63:0] d);
    int unsigned n;
    bit          sgn;
    logic [63:0] sh;
    case (f3)
      3'd0: begin n = 8;  sgn = 1; end
      3'd1: begin n = 16; sgn = 1; end
      3'd2: begin n = 32; sgn = 1; end
      3'd4: begin n = 8;  sgn = 0; end
      3'd5: begin n = 16; sgn = 0; end
      3'd6: begin n = 32; sgn = 0; end
      default: begin n = 64; sgn = 0; end
    endcase
    if (n == 64) return d;
    sh = d << (64 - n);
    if (sgn) return $signed(sh) >>> (64 - n);
    return sh >> (64 - n);
  endfunction

  // Stimulus for the next cycle.
  logic        s_alu_v, s_ld_v, s_iss_v;
  logic [4:0]  s_alu_rd, s_ld_rd, s_iss_rd, s_chk1, s_chk2;
  logic [63:0] s_alu_data, s_ld_data;
  logic [2:0]  s_f3;

  task automatic set_idle();
    s_alu_v = 0; s_alu_rd = 0; s_alu_data = 0;
    s_ld_v = 0; s_ld_rd = 0; s_f3 = 0; s_ld_data = 0;
    s_iss_v = 0; s_iss_rd = 0;
  endtask

  task automatic model_clear();
    m_held = 0; m_hrd = 0; m_hdata = 0; m_cnt = 0; m_stall = 0;
    m_pend = '0; m_clr_v = 0; m_clr_rd = 0;
    sb_q.delete();
  endtask

  // Advance the model across the edge that ends the current cycle.
  task automatic model_update();
    bit          acc, was_held, wv, wl;
    logic [4:0]  wrd;
    logic [63:0] wd;
    acc = s_ld_v && !m_held;
    was_held = m_held;
    wv = 0; wl = 0; wrd = 0; wd = 0;
    if (s_alu_v) begin
      wv = 1; wrd = s_alu_rd; wd = s_alu_data;
      if (acc) begin
        m_held = 1; m_hrd = s_ld_rd; m_hdata = m_ext(s_f3, s_ld_data);
      end
      if (was_held && m_cnt < STARVE) m_cnt++;
    end else if (m_held) begin
      wv = 1; wl = 1; wrd = m_hrd; wd = m_hdata; m_held = 0;
    end else if (acc) begin
      wv = 1; wl = 1; wrd = s_ld_rd; wd = m_ext(s_f3, s_ld_data);
    end
    if (!m_held) m_cnt = 0;
    m_stall = m_held && (m_cnt == STARVE);
    if (wv && wrd != 0) sb_q.push_back('{cyc + 1, wrd, wd});
    if (m_clr_v) m_pend[m_clr_rd] = 1'b0;
    if (s_iss_v && s_iss_rd != 0) m_pend[s_iss_rd] = 1'b1;
    m_clr_v = wl && (wrd != 0);
    m_clr_rd = wrd;
  endtask

  // One clock cycle: drive after the edge, check handshake/scoreboard outputs
  // before the next edge, then advance the model.
  task automatic step();
    @(posedge clk);
    #1;
    alu_valid = s_alu_v; alu_rd = s_alu_rd; alu_data = s_alu_data;
    ld_valid = s_ld_v; ld_rd = s_ld_rd; ld_funct3 = s_f3; ld_data = s_ld_data;
    iss_valid = s_iss_v; iss_rd = s_iss_rd;
    chk_addr1 = s_chk1; chk_addr2 = s_chk2;
    #3;
    chk("ld_ready", 64'(ld_ready), 64'(!m_held));
    chk("alu_stall", 64'(alu_stall), 64'(m_stall));
    chk("chk_busy1", 64'(chk_busy1), 64'(m_pend[s_chk1]));
    chk("chk_busy2", 64'(chk_busy2), 64'(m_pend[s_chk2]));
    model_update();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    nrst = 1'b0;
    set_idle();
    alu_valid = 0; ld_valid = 0; iss_valid = 0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    nrst = 1'b1;
  endtask

  task automatic expect_wr(input string name, input logic [4:0] a, input logic [63:0] d);
    chk({name, "_en"}, 64'(wr_en), 64'd1);
    chk({name, "_addr"}, 64'(wr_addr), 64'(a));
    chk({name, "_data"}, wrdata, d);
  endtask

  task automatic expect_nowr(input string name);
    chk(name, 64'(wr_en), 64'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: drains the scoreboard whenever the DUT writes
  // ---------------------------------------------------------------------------
  exp_t mon_e;
  always @(negedge clk) begin
    if (!nrst) begin
      chk("rst_wr_en", 64'(wr_en), 64'd0);
      chk("rst_ld_ready", 64'(ld_ready), 64'd0);
      chk("rst_alu_stall", 64'(alu_stall), 64'd0);
      chk("rst_busy", 64'({chk_busy1, chk_busy2}), 64'd0);
    end else if (wr_en) begin
      if (sb_q.size() == 0) begin
        chk("spurious_wr_en", 64'(wr_en), 64'd0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("wr_cycle", 64'(cyc), 64'(mon_e.cyc));
        chk("wr_addr", 64'(wr_addr), 64'(mon_e.rd));
        chk("wr_data", wrdata, mon_e.data);
      end
    end else if (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      chk("missing_wr_en", 64'(wr_en), 64'd1);
      void'(sb_q.pop_front());
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    nrst = 1'b1;
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    ld_valid = 0; ld_rd = 0; ld_funct3 = 0; ld_data = 0;
    iss_valid = 0; iss_rd = 0; chk_addr1 = 0; chk_addr2 = 0;
    set_idle();
    s_chk1 = 0; s_chk2 = 0;
    #2;
    do_reset();

    // Reset state: scan every register's busy bit while idle.
    for (int i = 0; i < 16; i++) begin
      s_chk1 = 5'(2 * i); s_chk2 = 5'(2 * i + 1);
      step();
      expect_nowr("idle_no_wr");
      chk("idle_ld_ready", 64'(ld_ready), 64'd1);
    end

    // Single ALU write, visible for exactly one cycle.
    set_idle(); s_alu_v = 1; s_alu_rd = 5; s_alu_data = 64'h1234;
    step();
    set_idle();
    step(); expect_wr("alu_x5", 5'd5, 64'h1234);
    step(); expect_nowr("alu_one_cycle");

    // ALU/load collision: ALU first, buffered LB next.
    set_idle(); s_alu_v = 1; s_alu_rd = 3; s_alu_data = 64'hdead_beef_0000_0003;
    s_ld_v = 1; s_ld_rd = 7; s_f3 = 3'b000; s_ld_data = 64'h80;
    step();
    set_idle();
    step(); expect_wr("coll_alu_x3", 5'd3, 64'hdead_beef_0000_0003);
    chk("coll_ld_ready_low", 64'(ld_ready), 64'd0);
    step(); expect_wr("coll_lb_x7", 5'd7, 64'hFFFF_FFFF_FFFF_FF80);
    step(); expect_nowr("coll_done");

    // Scoreboard: issue x9, then LWU response to x9.
    set_idle(); s_chk1 = 9; s_chk2 = 8; s_iss_v = 1; s_iss_rd = 9;
    step();
    set_idle();
    step(); chk("sb_busy_set", 64'(chk_busy1), 64'd1);
    s_ld_v = 1; s_ld_rd = 9; s_f3 = 3'b110; s_ld_data = 64'h0000_0000_FFFF_FFFF;
    step(); chk("sb_busy_inflight", 64'(chk_busy1), 64'd1);
    set_idle();
    step(); expect_wr("sb_lwu_x9", 5'd9, 64'h0000_0000_FFFF_FFFF);
    chk("sb_busy_during_wr", 64'(chk_busy1), 64'd1);
    step(); chk("sb_busy_cleared", 64'(chk_busy1), 64'd0);

    // Starvation: hold a load while the ALU keeps winning.
    set_idle(); s_alu_v = 1; s_alu_rd = 1; s_alu_data = 64'h11;
    s_ld_v = 1; s_ld_rd = 2; s_f3 = 3'b011; s_ld_data = 64'h0123_4567_89ab_cdef;
    step();
    for (int i = 0; i < STARVE; i++) begin
      set_idle(); s_alu_v = 1; s_alu_rd = 5'(20 + i); s_alu_data = 64'(i);
      step();
      chk("starve_no_stall_yet", 64'(alu_stall), 64'd0);
    end
    set_idle();
    step(); chk("starve_stall_high", 64'(alu_stall), 64'd1);
    step(); chk("starve_stall_clear", 64'(alu_stall), 64'd0);
    expect_wr("starve_ld_x2", 5'd2, 64'h0123_4567_89ab_cdef);

    // x0: issue and load to x0 change nothing.
    set_idle(); s_iss_v = 1; s_iss_rd = 0; s_chk1 = 0;
    step();
    set_idle(); s_ld_v = 1; s_ld_rd = 0; s_ld_data = 64'h55;
    step();
    set_idle();
    step(); expect_nowr("x0_no_wr");
    chk("x0_not_busy", 64'(chk_busy1), 64'd0);

    // Reset while HELD discards buffer and pending bits.
    set_idle(); s_iss_v = 1; s_iss_rd = 11; s_chk1 = 11;
    step();
    set_idle(); s_alu_v = 1; s_alu_rd = 4; s_alu_data = 64'h44;
    s_ld_v = 1; s_ld_rd = 11; s_f3 = 3'b011; s_ld_data = 64'h99;
    step();
    chk("held_busy11", 64'(chk_busy1), 64'd1);
    do_reset();
    set_idle();
    for (int i = 0; i < 16; i++) begin
      s_chk1 = 5'(2 * i); s_chk2 = 5'(2 * i + 1);
      step();
      expect_nowr("post_rst_no_wr");
    end

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end
      s_alu_v = !m_stall && ($urandom_range(0, 2) != 0);
      s_alu_rd = 5'($urandom_range(0, 31));
      s_alu_data = {$urandom, $urandom};
      s_ld_v = ($urandom_range(0, 1) != 0);
      s_ld_rd = 5'($urandom_range(0, 31));
      s_f3 = 3'($urandom_range(0, 7));
      s_ld_data = {$urandom, $urandom};
      s_iss_v = ($urandom_range(0, 3) == 0);
      s_iss_rd = 5'($urandom_range(0, 31));
      s_chk1 = 5'($urandom_range(0, 31));
      s_chk2 = 5'($urandom_range(0, 31));
      step();
    end

    set_idle();
    repeat (4) step();
    chk("sb_queue_drained", 64'(sb_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
